// File: rtl/sg_lock_ctrl_if.sv
// Signal bundle between the sync-lock controller and its environment.
// Reference/generated sync inputs plus lock status outputs.
interface sg_lock_ctrl_if;
    logic       cfg_valid;
    logic       v_change;
    logic       HSYNC_ref;
    logic       VSYNC_ref;
    logic       VSYNC_sg;
    logic       sg_reset_n;
    logic       locked;
    logic       lock_lost;
    logic [7:0] phase_offset;
    logic [2:0] state_o;

    modport slave (
        input  cfg_valid, v_change, HSYNC_ref, VSYNC_ref, VSYNC_sg,
        output sg_reset_n, locked, lock_lost, phase_offset, state_o
    );

    modport master (
        output cfg_valid, v_change, HSYNC_ref, VSYNC_ref, VSYNC_sg,
        input  sg_reset_n, locked, lock_lost, phase_offset, state_o
    );
endinterface

// File: rtl/sg_lock_ctrl.sv
// Sync-generator lock controller: waits for a stable reference, releases the
// syncgen, then measures VSYNC phase and tracks/holds lock.
module sg_lock_ctrl #(
    parameter int STABLE_FRAMES = 2,
    parameter int LOCK_FRAMES   = 3,
    parameter int PHASE_TOL     = 4,
    parameter int SIG_TIMEOUT   = 4095
) (
    input  logic           PCLK,
    input  logic           reset_n,
    sg_lock_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_STABLE = 3'd1,
        RELEASE     = 3'd2,
        TRACK       = 3'd3,
        LOCKED      = 3'd4
    } state_e;

    localparam logic [7:0]  STAB_N = 8'(STABLE_FRAMES);
    localparam logic [7:0]  LOCK_N = 8'(LOCK_FRAMES);
    localparam logic [7:0]  TOL_N  = 8'(PHASE_TOL);
    localparam logic [11:0] TO_N   = 12'(SIG_TIMEOUT);

    state_e      state_q, state_d;
    logic        hs_cur_q, hs_prev_q;
    logic        vr_cur_q, vr_prev_q;
    logic        vs_cur_q, vs_prev_q;
    logic [7:0]  stab_q, stab_d;
    logic [7:0]  good_q, good_d;
    logic        armed_q, armed_d;
    logic        src_q, src_d;
    logic [7:0]  win_q, win_d;
    logic [7:0]  off_q, off_d;
    logic [11:0] to_q, to_d;
    logic        lost_q, lost_d;
    logic        sgr_q, locked_q, ll_q, ll_d;

    logic        hs_fall, vr_fall, vs_fall;
    logic        other_fall, same_fall;
    logic        timeout, abort, win_en;
    logic        good, bad;
    logic [7:0]  stab_inc, good_inc;

    // Falling edges seen one cycle after the input changes (two-stage history).
    assign hs_fall = hs_prev_q & ~hs_cur_q;
    assign vr_fall = vr_prev_q & ~vr_cur_q;
    assign vs_fall = vs_prev_q & ~vs_cur_q;

    // src_q: 0 = window armed by reference edge, 1 = armed by generated edge
    assign other_fall = src_q ? vr_fall : vs_fall;
    assign same_fall  = src_q ? vs_fall : vr_fall;

    assign timeout  = (to_q == TO_N);
    assign abort    = ~bus.cfg_valid | bus.v_change | timeout;
    assign stab_inc = (stab_q == STAB_N) ? stab_q : stab_q + 8'd1;
    assign good_inc = (good_q == LOCK_N) ? good_q : good_q + 8'd1;

    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        good_d  = good_q;
        armed_d = armed_q;
        src_d   = src_q;
        win_d   = win_q;
        off_d   = off_q;
        lost_d  = lost_q;
        ll_d    = 1'b0;
        good    = 1'b0;
        bad     = 1'b0;

        if (state_q == IDLE || hs_fall)
            to_d = '0;
        else if (to_q != 12'hFFF)
            to_d = to_q + 12'd1;
        else
            to_d = to_q;

        if (hs_fall)
            lost_d = 1'b0;
        else if (timeout && state_q != IDLE)
            lost_d = 1'b1;

        // The reference edge that leaves RELEASE also opens the first frame window.
        win_en = (state_q == TRACK) || (state_q == LOCKED) ||
                 (state_q == RELEASE && vr_fall);

        // win_q holds the cycle distance from the arming edge, so the arm cycle
        // itself is offset 0 and the next registered value is 1.
        if (win_en) begin
            if (!armed_q) begin
                if (vr_fall && vs_fall) begin
                    good  = 1'b1;
                    off_d = 8'd0;
                end else if (vr_fall || vs_fall) begin
                    armed_d = 1'b1;
                    src_d   = vs_fall;
                    win_d   = 8'd1;
                end
            end else begin
                if (other_fall && win_q <= TOL_N) begin
                    good    = 1'b1;
                    off_d   = win_q;
                    armed_d = 1'b0;
                end else if (same_fall) begin
                    bad   = 1'b1;
                    off_d = win_q;
                    win_d = 8'd1;
                end else if (win_q > TOL_N) begin
                    bad     = 1'b1;
                    off_d   = win_q;
                    armed_d = 1'b0;
                end else if (win_q != 8'hFF) begin
                    win_d = win_q + 8'd1;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.cfg_valid && !bus.v_change && !lost_q)
                    state_d = WAIT_STABLE;
            end
            WAIT_STABLE: begin
                if (vr_fall) begin
                    stab_d = stab_inc;
                    if (stab_inc == STAB_N)
                        state_d = RELEASE;
                end
            end
            RELEASE, TRACK: begin
                if (state_q == RELEASE && vr_fall)
                    state_d = TRACK;
                if (good) begin
                    good_d = good_inc;
                    if (good_inc == LOCK_N)
                        state_d = LOCKED;
                end else if (bad) begin
                    good_d = 8'd0;
                end
            end
            LOCKED: begin
                if (bad) begin
                    state_d = IDLE;
                    ll_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && abort) begin
            state_d = IDLE;
            ll_d    = (state_q == LOCKED);
        end

        if (state_d == IDLE) begin
            stab_d  = 8'd0;
            good_d  = 8'd0;
            armed_d = 1'b0;
            win_d   = 8'd0;
            to_d    = '0;
        end
    end

    always_ff @(posedge PCLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            hs_cur_q  <= 1'b1;
            hs_prev_q <= 1'b1;
            vr_cur_q  <= 1'b1;
            vr_prev_q <= 1'b1;
            vs_cur_q  <= 1'b1;
            vs_prev_q <= 1'b1;
            stab_q    <= 8'd0;
            good_q    <= 8'd0;
            armed_q   <= 1'b0;
            src_q     <= 1'b0;
            win_q     <= 8'd0;
            off_q     <= 8'd0;
            to_q      <= 12'd0;
            lost_q    <= 1'b0;
            sgr_q     <= 1'b0;
            locked_q  <= 1'b0;
            ll_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            hs_cur_q  <= bus.HSYNC_ref;
            hs_prev_q <= hs_cur_q;
            vr_cur_q  <= bus.VSYNC_ref;
            vr_prev_q <= vr_cur_q;
            vs_cur_q  <= bus.VSYNC_sg;
            vs_prev_q <= vs_cur_q;
            stab_q    <= stab_d;
            good_q    <= good_d;
            armed_q   <= armed_d;
            src_q     <= src_d;
            win_q     <= win_d;
            off_q     <= off_d;
            to_q      <= to_d;
            lost_q    <= lost_d;
            sgr_q     <= (state_d == RELEASE) || (state_d == TRACK) || (state_d == LOCKED);
            locked_q  <= (state_d == LOCKED);
            ll_q      <= ll_d;
        end
    end

    assign bus.sg_reset_n   = sgr_q;
    assign bus.locked       = locked_q;
    assign bus.lock_lost    = ll_q;
    assign bus.phase_offset = off_q;
    assign bus.state_o      = state_q;

endmodule
